// File: rtl/fetch_queue_pkg.sv
// Shared core width parameters, imported by the fetch queue and the decode unit.
package fetch_queue_pkg;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PID_W   = 20;
  localparam int unsigned TID_W   = 16;
  localparam int unsigned CNT_W   = 64;
  localparam int unsigned QDEPTH  = 4;
endpackage

// File: rtl/fetch_queue_mem.sv
// One-write, one-read register array without reset; read is asynchronous.
module fetch_queue_mem #(
  parameter int unsigned DataW = 8,
  parameter int unsigned Depth = 4,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clock_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);
  logic [DataW-1:0] mem_q [Depth];

  always_ff @(posedge clock_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: tags each push with a major ID and presents
// the head entry on registered outputs whenever decode is not stalled.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned addressWidth            = ADDR_W,
  parameter int unsigned instructionWidth        = INSTR_W,
  parameter int unsigned PidSize                 = PID_W,
  parameter int unsigned TidSize                 = TID_W,
  parameter int unsigned instructionCounterWidth = CNT_W,
  parameter int unsigned queueDepth              = QDEPTH
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic [instructionWidth-1:0]        instruction_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic                               is64Bit_i,
  input  logic [PidSize-1:0]                 instructionPid_i,
  input  logic [TidSize-1:0]                 instructionTid_i,
  input  logic                               flush_i,
  input  logic                               stall_i,
  output logic                               stall_o,
  output logic                               enable_o,
  output logic [instructionWidth-1:0]        instruction_o,
  output logic [addressWidth-1:0]            instructionAddress_o,
  output logic                               is64Bit_o,
  output logic [PidSize-1:0]                 instructionPid_o,
  output logic [TidSize-1:0]                 instructionTid_o,
  output logic [instructionCounterWidth-1:0] instructionMajId_o
);
  localparam int unsigned PtrW   = $clog2(queueDepth);
  localparam int unsigned CntW   = instructionCounterWidth;
  localparam int unsigned EntryW = 1 + PidSize + TidSize + addressWidth + instructionWidth + CntW;
  localparam logic [PtrW:0] FullCount = (PtrW+1)'(queueDepth);

  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [PtrW:0]     count_q, count_d;
  logic [CntW-1:0]   majid_q;
  logic              valid_q;
  logic [EntryW-1:0] head_q, wdata, rdata;
  logic              push, pop;

  assign stall_o = (count_q == FullCount);
  assign push    = enable_i & ~stall_o & ~flush_i;
  assign pop     = ~stall_i & ~flush_i & (count_q != '0);

  assign wdata = {is64Bit_i, instructionPid_i, instructionTid_i,
                  instructionAddress_i, instruction_i, majid_q};

  fetch_queue_mem #(
    .DataW (EntryW),
    .Depth (queueDepth),
    .AddrW (PtrW)
  ) u_mem (
    .clock_i (clock_i),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (wdata),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (PtrW+1)'(1);
    else if (pop && !push) count_d = count_q - (PtrW+1)'(1);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      majid_q <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
    end else if (flush_i) begin
      // Major ID counter deliberately survives a flush so IDs stay unique.
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wptr_q  <= wptr_q + PtrW'(1);
        majid_q <= majid_q + CntW'(1);
      end
      if (pop) rptr_q <= rptr_q + PtrW'(1);
      if (!stall_i) begin
        valid_q <= pop;
        if (pop) head_q <= rdata;
      end
    end
  end

  assign enable_o = valid_q;
  assign {is64Bit_o, instructionPid_o, instructionTid_o,
          instructionAddress_o, instruction_o, instructionMajId_o} = head_q;
endmodule

// File: tb/tb_fetch_queue.sv
// Randomised scoreboard bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  localparam int D = 4;

  typedef struct {
    logic [31:0] ins;
    logic [63:0] addr;
    logic        is64;
    logic [19:0] pid;
    logic [15:0] tid;
    logic [63:0] id;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        en_i = 1'b0, fl_i = 1'b0, st_i = 1'b0;
  logic [31:0] ins_i = '0;
  logic [63:0] addr_i = '0;
  logic        is64_i = 1'b0;
  logic [19:0] pid_i = '0;
  logic [15:0] tid_i = '0;
  logic        stall_o, enable_o, is64_o;
  logic [31:0] ins_o;
  logic [63:0] addr_o, id_o;
  logic [19:0] pid_o;
  logic [15:0] tid_o;

  int n_cmp = 0;
  int n_err = 0;

  ent_t        mq[$];
  ent_t        sq[$];
  ent_t        last;
  logic [63:0] ctr = '0;
  bit          exp_en = 1'b0;

  always #5 clock = ~clock;

  fetch_queue dut (
    .clock_i              (clock),
    .reset_i              (reset),
    .enable_i             (en_i),
    .instruction_i        (ins_i),
    .instructionAddress_i (addr_i),
    .is64Bit_i            (is64_i),
    .instructionPid_i     (pid_i),
    .instructionTid_i     (tid_i),
    .flush_i              (fl_i),
    .stall_i              (st_i),
    .stall_o              (stall_o),
    .enable_o             (enable_o),
    .instruction_o        (ins_o),
    .instructionAddress_o (addr_o),
    .is64Bit_o            (is64_o),
    .instructionPid_o     (pid_o),
    .instructionTid_o     (tid_o),
    .instructionMajId_o   (id_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: a new output is presented after an edge that saw no stall, flush or reset.
  initial begin
    bit ps, pf, pr;
    ent_t e;
    forever begin
      @(posedge clock);
      ps = st_i; pf = fl_i; pr = reset;
      #1;
      if (enable_o && !ps && !pf && pr) begin
        if (sq.size() == 0) begin
          chk("spurious_output", 64'(enable_o), 64'(0));
        end else begin
          e = sq.pop_front();
          chk("mon_instruction", 64'(ins_o), 64'(e.ins));
          chk("mon_address",     addr_o,     e.addr);
          chk("mon_is64",        64'(is64_o), 64'(e.is64));
          chk("mon_pid",         64'(pid_o), 64'(e.pid));
          chk("mon_tid",         64'(tid_o), 64'(e.tid));
          chk("mon_majid",       id_o,       e.id);
        end
      end
    end
  end

  task automatic step(input bit en, input bit fl, input bit st,
                      input logic [31:0] ins, input logic [63:0] addr);
    ent_t e;
    bit   do_push, do_pop;
    @(negedge clock);
    en_i = en; fl_i = fl; st_i = st; ins_i = ins; addr_i = addr;
    is64_i = 1'($urandom); pid_i = 20'($urandom); tid_i = 16'($urandom);
    #1;
    chk("stall_o", 64'(stall_o), 64'(mq.size() == D));
    do_push = en && !fl && (mq.size() < D);
    do_pop  = !st && !fl && (mq.size() > 0);
    if (fl) begin
      mq.delete();
      exp_en = 1'b0;
    end else begin
      if (!st) begin
        exp_en = do_pop;
        if (do_pop) begin
          last = mq.pop_front();
          sq.push_back(last);
        end
      end
      if (do_push) begin
        e.ins = ins; e.addr = addr; e.is64 = is64_i; e.pid = pid_i; e.tid = tid_i; e.id = ctr;
        mq.push_back(e);
        ctr = ctr + 64'd1;
      end
    end
    @(posedge clock);
    #1;
    chk("enable_o", 64'(enable_o), 64'(exp_en));
    if (exp_en) begin
      chk("held_instruction", 64'(ins_o), 64'(last.ins));
      chk("held_majid",       id_o,       last.id);
    end
  endtask

  task automatic reset_mid();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst_enable_o",    64'(enable_o), 64'(0));
    chk("rst_stall_o",     64'(stall_o),  64'(0));
    chk("rst_instruction", 64'(ins_o),    64'(0));
    chk("rst_address",     addr_o,        64'(0));
    chk("rst_is64",        64'(is64_o),   64'(0));
    chk("rst_pid",         64'(pid_o),    64'(0));
    chk("rst_tid",         64'(tid_o),    64'(0));
    chk("rst_majid",       id_o,          64'(0));
    chk("pending_at_reset", 64'(sq.size()), 64'(0));
    mq.delete(); sq.delete(); ctr = '0; exp_en = 1'b0;
    last = '{default: '0};
    en_i = 1'b0; fl_i = 1'b0; st_i = 1'b0;
    #1 reset = 1'b1;
  endtask

  initial begin
    last = '{default: '0};
    reset_mid();

    // Single instruction through an empty queue.
    step(1, 0, 0, 32'hFC00002A, 64'h1000);
    step(0, 0, 0, '0, '0);
    chk("d036_instruction", 64'(ins_o), 64'hFC00002A);
    chk("d036_address",     addr_o,     64'h1000);
    chk("d036_majid",       id_o,       64'd0);
    step(0, 0, 0, '0, '0);

    // Fill under stall, overflow attempt, then drain.
    reset_mid();
    for (int i = 0; i < 5; i++) step(1, 0, 1, $urandom, 64'(4 * i));
    chk("d037_full", 64'(stall_o), 64'd1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, '0, '0);

    // Full queue with continuous push and pop.
    for (int i = 0; i < 4; i++) step(1, 0, 1, $urandom, 64'(i));
    for (int i = 0; i < 8; i++) step(1, 0, 0, $urandom, 64'(16 + i));
    for (int i = 0; i < 6; i++) step(0, 0, 0, '0, '0);

    // Flush overriding a push; ID counter survives.
    reset_mid();
    for (int i = 0; i < 3; i++) step(1, 0, 1, $urandom, 64'(8 * i));
    step(1, 1, 1, 32'hDEADBEEF, 64'h99);
    chk("d039_enable_after_flush", 64'(enable_o), 64'd0);
    chk("d039_stall_after_flush",  64'(stall_o),  64'd0);
    step(1, 0, 0, 32'h12345678, 64'h200);
    step(0, 0, 0, '0, '0);
    chk("d039_majid", id_o, 64'd3);
    step(0, 0, 0, '0, '0);

    // Major ID wrap from all-ones.
    reset_mid();
    @(negedge clock);
    force dut.majid_q = '1;
    #1 release dut.majid_q;
    ctr = '1;
    step(1, 0, 0, $urandom, 64'h300);
    step(1, 0, 0, $urandom, 64'h304);
    chk("d040_majid_max", id_o, 64'hFFFF_FFFF_FFFF_FFFF);
    step(0, 0, 0, '0, '0);
    chk("d040_majid_wrap", id_o, 64'd0);
    step(0, 0, 0, '0, '0);

    // Asynchronous reset with entries queued.
    step(1, 0, 1, $urandom, 64'h400);
    step(1, 0, 1, $urandom, 64'h404);
    reset_mid();
    step(0, 0, 0, '0, '0);
    step(0, 0, 0, '0, '0);
    step(1, 0, 0, $urandom, 64'h500);
    step(0, 0, 0, '0, '0);
    chk("d041_first_majid", id_o, 64'd0);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom % 10) < 7, ($urandom % 40) == 0, ($urandom % 10) < ((i / 300) % 2 ? 6 : 2),
           $urandom, {$urandom, $urandom});
    end
    for (int i = 0; i < 6; i++) step(0, 0, 0, '0, '0);
    #2;
    chk("scoreboard_drained", 64'(sq.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter addressWidth, default 64, instruction address width.
REQ-002 Parameter instructionWidth, default 32, fixed-size POWER instruction width.
REQ-003 Parameter PidSize, default 20, and TidSize, default 16, process and thread ID widths.
REQ-004 Parameter instructionCounterWidth, default 64, major ID width.
REQ-005 Parameter queueDepth, default 4, entry count; power of 2, at least 2.
REQ-006 Port clock_i, input, 1, sole clock; all state updates on the rising edge.
REQ-007 Port reset_i, input, 1, asynchronous active-low reset.
REQ-008 Port enable_i, input, 1, fetch presents a valid instruction this cycle.
REQ-009 Port instruction_i, input, instructionWidth, instruction word.
REQ-010 Port instructionAddress_i, input, addressWidth, instruction address.
REQ-011 Port is64Bit_i, input, 1, 64-bit mode flag; instructionPid_i, input, PidSize; instructionTid_i, input, TidSize.
REQ-012 Port flush_i, input, 1, synchronous queue flush.
REQ-013 Port stall_i, input, 1, decode cannot accept a new instruction.
REQ-014 Port stall_o, output, 1, queue full; fetch shall not present.
REQ-015 Port enable_o, output, 1, outputs carry a valid instruction for decode.
REQ-016 Ports instruction_o, instructionAddress_o, is64Bit_o, instructionPid_o and instructionTid_o, outputs, widths as the matching inputs, registered head entry.
REQ-017 Port instructionMajId_o, output, instructionCounterWidth, major ID of the presented instruction.

Function
REQ-018 Push: on a rising edge with enable_i=1, stall_o=0 and flush_i=0, the queue shall write the input fields plus the current major ID counter value to the tail entry.
REQ-019 On every push the major ID counter shall increment by 1, wrapping modulo 2^instructionCounterWidth.
REQ-020 A push attempt while stall_o=1 shall be ignored: nothing written and no counter change.
REQ-021 stall_o shall be combinational and equal 1 exactly when occupancy equals queueDepth.
REQ-022 Pop: on a rising edge with stall_i=0, flush_i=0 and pre-edge occupancy greater than 0, the queue shall register the head entry onto the outputs, set enable_o=1 and free the entry.
REQ-023 On a rising edge with stall_i=0 and pre-edge occupancy 0, enable_o shall become 0 and the data outputs shall hold.
REQ-024 While stall_i=1, all outputs including enable_o shall hold their values and no pop shall occur.
REQ-025 A push and a pop on the same edge shall leave occupancy unchanged, and both shall complete.
REQ-026 Latency: an instruction pushed into an empty queue at edge N shall appear with enable_o=1 after edge N+1.
REQ-027 Order: output order shall equal push order, and major IDs shall be strictly consecutive across outputs, modulo wrap.
REQ-028 Read and write pointers shall be log2(queueDepth) bits wide and wrap naturally; occupancy shall be log2(queueDepth)+1 bits wide.
REQ-029 Flush: on an edge with flush_i=1, occupancy and both pointers shall clear, enable_o shall become 0, and no push or pop shall occur; flush shall override enable_i and stall_i.
REQ-030 Flush shall not reset the major ID counter, so IDs stay unique across flushes.

Reset
REQ-031 While reset_i=0, asynchronously: occupancy, pointers and the major ID counter shall be 0; enable_o, is64Bit_o and all data and ID outputs shall be 0; stall_o shall be 0.
REQ-032 Reset asserted mid-operation shall discard all entries; the first push after release shall carry major ID 0.
REQ-033 Storage array contents need no reset; an entry shall never be output unless it was written since the last reset or flush.

Structure
REQ-034 The width parameters shall live in the shared core parameter package used by the decode unit: address, instruction, PID, TID and counter widths.
REQ-035 One sub-module is natural: fetch_queue_mem, a parameterised one-write, one-read register array with no reset; pointers, counter and control stay in fetch_queue.

Verification
REQ-036 Reset, then push one instruction 0xFC00002A at address 0x1000 into an empty queue, stall_i=0 -> after the next edge, enable_o=1, instruction_o=0xFC00002A, instructionAddress_o=0x1000, instructionMajId_o=0; after the following edge, enable_o=0.
REQ-037 Hold stall_i=1 and push 4 instructions at addresses 0x0, 0x4, 0x8, 0xC -> stall_o=1 after the 4th push; a 5th push is ignored; then release stall_i -> addresses 0x0, 0x4, 0x8, 0xC emerge on consecutive cycles with IDs 0..3, and stall_o clears after the first pop.
REQ-038 With the queue full, stall_i=0 and enable_i=1 held for 8 cycles -> only pushes accepted while stall_o=0 appear; output IDs contiguous with no gaps or duplicates.
REQ-039 Push 3 instructions, then assert flush_i together with enable_i -> enable_o=0 after the edge and occupancy 0; the next push emerges with ID 3.
REQ-040 Preload the major ID counter to 2^64-1 via forced state, then push 2 -> output IDs 0xFFFFFFFFFFFFFFFF, then 0.
REQ-041 Drive reset_i low between clock edges while 2 entries are queued -> outputs 0 immediately, with no clock edge needed; after release, no stale entry emerges and the first new push carries ID 0.
